round_robin_arbiter4: RTL
=========================

ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive cycles one requester may hold a grant; legal range 2..255.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 req    input  4  request bit per requester; a requester holds its bit high until it has been served.
REQ-005 done   input  1  current owner finished; sampled only while a grant is active.
REQ-006 grant  output 4  one-hot registered grant; all-zero when no owner.
REQ-007 owner  output 2  index of current grant holder; valid only while busy=1.
REQ-008 busy   output 1  high while any grant bit is high.
REQ-009 preempt output 1  one-cycle pulse in the cycle after a grant is withdrawn by hold timeout.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-011 In IDLE or GAP with req != 0, the block SHALL select the winner and enter GRANT; grant, owner and busy go high on the next rising edge, giving 1-cycle latency.
REQ-012 In IDLE or GAP with req == 0, the block SHALL enter IDLE or stay there, with grant = 0.
REQ-013 Winner selection SHALL be rotating priority: search order is last_ptr+1, last_ptr+2, last_ptr+3, last_ptr (all mod 4), and the first set req bit wins.
REQ-014 In GRANT, the grant SHALL be held unchanged while req[owner]=1, done=0 and hold_cnt < MAX_HOLD-1.
REQ-015 In GRANT, release SHALL occur on any of: done=1; req[owner]=0; hold_cnt == MAX_HOLD-1.
REQ-016 On release the block SHALL enter GAP, clear grant to 0 on the next edge, and load last_ptr with owner.
REQ-017 GAP SHALL last exactly one cycle with grant = 0, so there is always at least one dead cycle between owners.
REQ-018 hold_cnt SHALL reset to 0 on every entry to GRANT and increment by 1 per GRANT cycle; its width is 8 bits.
REQ-019 A grant SHALL last at most MAX_HOLD cycles.
REQ-020 preempt SHALL pulse high for one cycle, coincident with the GAP cycle, only when release was caused solely by timeout.
REQ-021 If done=1 or req[owner]=0 in the timeout cycle, preempt SHALL stay 0.
REQ-022 A requester released by timeout that still requests SHALL be lowest priority in the next arbitration; this follows from last_ptr.
REQ-023 Requests arriving or dropping during GRANT for non-owners SHALL have no effect until the next IDLE/GAP decision.
REQ-024 done while not in GRANT SHALL be ignored.
REQ-025 grant SHALL never have more than one bit set, and owner SHALL always equal the index of the set bit.

Reset
REQ-026 reset=0 SHALL asynchronously force: state=IDLE, grant=0, owner=0, busy=0, preempt=0, hold_cnt=0, last_ptr=3 (requester 0 highest priority first).
REQ-027 Reset asserted mid-grant SHALL drop grant within the same cycle, without passing through GAP.
REQ-028 After reset deasserts, the first arbitration SHALL occur on the first rising edge at which reset=1.

Structure
REQ-029 Shared package rr_arb_pkg SHALL hold: NREQ=4, the IDX width constant, the state enumeration {IDLE, GRANT, GAP}, and the hold-counter width.
REQ-030 The rotating-priority search SHALL live in one combinational sub-module, rr_pick, with inputs req[3:0] and last_ptr[1:0] and outputs valid and idx[1:0].
REQ-031 All outputs SHALL be driven directly from flops; there is no combinational req-to-grant path.

Verification
REQ-032 Reset release with req=4'b1010 -> one edge later grant=4'b0010, owner=1, busy=1.
REQ-033 req=4'b1111 held, done pulsed on 3rd grant cycle each time -> grant sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between each.
REQ-034 MAX_HOLD=8, req=4'b0001 held, done=0 -> grant high exactly 8 cycles, then one GAP cycle with preempt=1, then grant=0001 again.
REQ-035 In the 8th grant cycle assert done=1 -> release, preempt=0.
REQ-036 Owner 2 granted, req[2] dropped while req=4'b1001 -> GAP, then grant=1000; req0 is not chosen because last_ptr=2.
REQ-037 Assert reset mid-grant -> grant=0 and busy=0 before the next edge; after release with req=4'b0100 -> grant=0100.

Source files
------------

// File: rtl/round_robin_arbiter4_pkg.sv
// Purpose : shared constants, FSM state type and helpers for the 4-way round-robin arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a; requesters hold req high until served, the arbiter never queues.
package rr_arb_pkg;

    localparam int NREQ   = 4;
    localparam int IDX_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/round_robin_arbiter4_if.sv
// Purpose : request/grant bundle between the requesters and the arbiter.
// Latency : n/a (wiring only).
// Backpressure: requesters keep req asserted until granted; done releases the grant.
// Ports   : req/done driven by requesters, grant/owner/busy/preempt driven by the arbiter.
interface round_robin_arbiter4_if;
    import rr_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic             done;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] owner;
    logic             busy;
    logic             preempt;

    // Arbiter side.
    modport master (
        input  req,
        input  done,
        output grant,
        output owner,
        output busy,
        output preempt
    );

    // Requester side.
    modport slave (
        output req,
        output done,
        input  grant,
        input  owner,
        input  busy,
        input  preempt
    );

endinterface

// File: rtl/round_robin_arbiter4_pick.sv
// Purpose : rotating-priority winner search, starting one past the last served requester.
// Latency : combinational, zero cycles.
// Backpressure: none; valid_o low when no request is pending.
// Ports   : req_i request vector, last_ptr_i last owner; valid_o/idx_o winner.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the lowest priority (last_ptr itself) to the highest (last_ptr+1)
    // so the final overwrite is the highest-priority set bit. The 2-bit add wraps mod 4.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = last_ptr_i;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter4.sv
// Purpose : 4-way round-robin arbiter with hold timeout and a one-cycle gap between owners.
// Latency : 1 cycle req->grant; all outputs registered.
// Backpressure: grant held until done, req drop or MAX_HOLD cycles; preempt flags a timeout release.
// Ports   : clk_i, rst_ni (async active-low), arb_if master modport (req/done in, grant/owner/busy/preempt out).
module round_robin_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    round_robin_arbiter4_if.master  arb_if
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              preempt_q, preempt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  last_ptr_q, last_ptr_d;

    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic              timeout;
    logic              early_rel;
    logic              release_now;

    rr_pick u_pick (
        .req_i      (arb_if.req),
        .last_ptr_i (last_ptr_q),
        .valid_o    (pick_vld),
        .idx_o      (pick_idx)
    );

    assign timeout     = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign early_rel   = arb_if.done | ~arb_if.req[owner_q];
    assign release_now = early_rel | timeout;

    // State register. last_ptr resets to 3 so requester 0 is first in line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_ptr_q <= IDX_W'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            hold_cnt_q <= hold_cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    // Next-state logic. GAP never holds: it re-arbitrates immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = pick_vld ? GRANT : IDLE;
            GRANT:     state_d = release_now ? GAP : GRANT;
            default:   state_d = IDLE;
        endcase
    end

    // Output / datapath next values, all landing in flops.
    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        preempt_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            GRANT: begin
                if (release_now) begin
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    last_ptr_d = owner_q;
                    // Only a pure timeout counts as preemption.
                    preempt_d  = timeout & ~early_rel;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                if (pick_vld) begin
                    grant_d    = idx2onehot(pick_idx);
                    owner_d    = pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    assign arb_if.grant   = grant_q;
    assign arb_if.owner   = owner_q;
    assign arb_if.busy    = busy_q;
    assign arb_if.preempt = preempt_q;

endmodule
